// File: rtl/cga_text_writer.sv
// Terminal-style byte writer for the 80x25 CGA text buffer: cursor tracking,
// CR/LF/BS handling, line wrap, RAM-to-RAM scroll and full-screen clear.
module cga_text_writer #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 25,
  parameter logic [15:0] CLEAR_CELL = 16'h0720
) (
  input  logic        clock_25,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic [7:0]  rx_attr,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        clear,
  output logic [10:0] address,
  output logic [15:0] wdata,
  output logic        we,
  input  logic [15:0] rdata,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, PUT, SCROLL_RD, SCROLL_WR, FILL_LINE, CLEAR_ALL
  } state_t;

  localparam logic [10:0] COLS_A      = 11'(COLS);
  localparam logic [10:0] SCROLL_LAST = 11'(COLS * (ROWS - 1) - 1);
  localparam logic [10:0] FILL_FIRST  = 11'(COLS * (ROWS - 1));
  localparam logic [10:0] LAST_CELL   = 11'(COLS * ROWS - 1);
  localparam logic [6:0]  X_LAST      = 7'(COLS - 1);
  localparam logic [4:0]  Y_LAST      = 5'(ROWS - 1);

  state_t      state_q;
  logic [6:0]  x_q;
  logic [4:0]  y_q;
  logic [10:0] idx_q;
  logic [10:0] addr_q;
  logic [15:0] wdata_q;
  logic        we_q;
  logic [10:0] cell_addr_d;

  // y*80 as (y<<6)+(y<<4); peaks at 1999, so 11 bits never overflow
  assign cell_addr_d = ({6'b0, y_q} << 6) + ({6'b0, y_q} << 4) + {4'b0, x_q};

  always_ff @(posedge clock_25) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clear) begin
            state_q <= CLEAR_ALL;
            addr_q  <= '0;
            wdata_q <= CLEAR_CELL;
            we_q    <= 1'b1;
          end else if (rx_valid) begin
            case (rx_data)
              8'h0D: x_q <= '0;
              8'h0A: begin
                if (y_q < Y_LAST) begin
                  y_q <= y_q + 5'd1;
                end else begin
                  state_q <= SCROLL_RD;
                  idx_q   <= '0;
                  addr_q  <= COLS_A;
                end
              end
              8'h08: if (x_q != '0) x_q <= x_q - 7'd1;
              default: begin
                state_q <= PUT;
                addr_q  <= cell_addr_d;
                wdata_q <= {rx_attr, rx_data};
                we_q    <= 1'b1;
              end
            endcase
          end
        end
        PUT: begin
          if (x_q < X_LAST) begin
            x_q     <= x_q + 7'd1;
            state_q <= IDLE;
          end else begin
            x_q <= '0;
            if (y_q < Y_LAST) begin
              y_q     <= y_q + 5'd1;
              state_q <= IDLE;
            end else begin
              state_q <= SCROLL_RD;
              idx_q   <= '0;
              addr_q  <= COLS_A;
            end
          end
        end
        SCROLL_RD: begin
          state_q <= SCROLL_WR;
          addr_q  <= idx_q;
          we_q    <= 1'b1;
        end
        SCROLL_WR: begin
          if (idx_q == SCROLL_LAST) begin
            state_q <= FILL_LINE;
            idx_q   <= '0;
            addr_q  <= FILL_FIRST;
            wdata_q <= CLEAR_CELL;
            we_q    <= 1'b1;
          end else begin
            state_q <= SCROLL_RD;
            idx_q   <= idx_q + 11'd1;
            addr_q  <= idx_q + 11'd1 + COLS_A;
          end
        end
        FILL_LINE, CLEAR_ALL: begin
          if (addr_q == LAST_CELL) begin
            state_q <= IDLE;
            if (state_q == CLEAR_ALL) begin
              x_q <= '0;
              y_q <= '0;
            end
          end else begin
            addr_q <= addr_q + 11'd1;
            we_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Scroll copy forwards the RAM read issued in the preceding SCROLL_RD cycle
  assign wdata    = (state_q == SCROLL_WR) ? rdata : wdata_q;
  assign address  = addr_q;
  assign we       = we_q;
  assign cursor_x = x_q;
  assign cursor_y = y_q;
  assign busy     = (state_q != IDLE);
  assign rx_ready = (state_q == IDLE) && !clear;

endmodule

// File: tb/tb_cga_text_writer.sv
// Directed bench for cga_text_writer with a behavioural video RAM and a
// scoreboard of expected {address, data} writes.
module tb_cga_text_writer;

  logic        clock_25 = 1'b0;
  logic        reset_n  = 1'b0;
  logic [7:0]  rx_data  = '0;
  logic [7:0]  rx_attr  = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        clear    = 1'b0;
  logic [10:0] address;
  logic [15:0] wdata;
  logic        we;
  logic [15:0] rdata    = '0;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        busy;

  logic        preload  = 1'b0;
  logic [15:0] ram     [0:1999];
  logic [15:0] exp_scr [0:1999];
  logic [26:0] sb [$];
  int total = 0;
  int bad   = 0;
  int ex = 0;
  int ey = 0;
  int nbusy;

  cga_text_writer dut (
    .clock_25 (clock_25),
    .reset_n  (reset_n),
    .rx_data  (rx_data),
    .rx_attr  (rx_attr),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .clear    (clear),
    .address  (address),
    .wdata    (wdata),
    .we       (we),
    .rdata    (rdata),
    .cursor_x (cursor_x),
    .cursor_y (cursor_y),
    .busy     (busy)
  );

  always #5 clock_25 = ~clock_25;

  // Synchronous video RAM: read data one cycle after address, old data on collision
  always @(posedge clock_25) begin
    if (preload) begin
      for (int i = 0; i < 2000; i++) ram[i] <= 16'(i);
    end else begin
      if (we) ram[address] <= wdata;
      rdata <= ram[address];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every cycle advance goes through here so each write is scored
  task automatic tick();
    logic [26:0] e;
    @(negedge clock_25);
    if (we === 1'b1) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL write_unexpected observed=%0h:%0h expected=none", address, wdata);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        total++;
        assert ({address, wdata} === e) else begin
          bad++;
          $error("FAIL write observed=%0h:%0h expected=%0h:%0h", address, wdata, e[26:16], e[15:0]);
        end
      end
    end
  endtask

  task automatic expect_write(input int a, input logic [15:0] d);
    sb.push_back({11'(a), d});
    exp_scr[a] = d;
  endtask

  task automatic expect_scroll();
    for (int i = 0; i < 1920; i++) expect_write(i, exp_scr[i + 80]);
    for (int i = 1920; i < 2000; i++) expect_write(i, 16'h0720);
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] a);
    rx_data  = d;
    rx_attr  = a;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Printable byte that does not scroll: one write, cursor advances after PUT
  task automatic print(input logic [7:0] d, input logic [7:0] a);
    expect_write(ey * 80 + ex, {a, d});
    send(d, a);
    tick();
    ex++;
    if (ex == 80) begin
      ex = 0;
      ey++;
    end
  endtask

  task automatic lf();
    send(8'h0A, 8'h00);
    ey++;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      n++;
      tick();
    end
  endtask

  task automatic chk_cursor(input string tag);
    chk({tag, "_x"}, 32'(cursor_x), 32'(ex));
    chk({tag, "_y"}, 32'(cursor_y), 32'(ey));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    ex = 0;
    ey = 0;
  endtask

  task automatic do_preload();
    preload = 1'b1;
    tick();
    preload = 1'b0;
    for (int i = 0; i < 2000; i++) exp_scr[i] = 16'(i);
  endtask

  initial begin
    // Reset state, sampled while reset is held
    tick();
    tick();
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_addr", 32'(address), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(rx_ready), 32'd1);
    chk_cursor("rst");
    reset_n = 1'b1;
    tick();

    // Printable write at (0,0)
    expect_write(0, 16'h1E41);
    send(8'h41, 8'h1E);
    chk("put_ready_low", 32'(rx_ready), 32'd0);
    chk("put_busy", 32'(busy), 32'd1);
    tick();
    chk("put_ready_back", 32'(rx_ready), 32'd1);
    ex = 1;
    chk_cursor("put");

    // Control codes from (5,3)
    for (int i = 0; i < 3; i++) lf();
    for (int i = 0; i < 4; i++) print(8'h30 + 8'(i), 8'h07);
    chk_cursor("at53");
    send(8'h08, 8'h00);
    ex = 4;
    chk("bs_we", 32'(we), 32'd0);
    chk_cursor("bs");
    send(8'h0D, 8'h00);
    ex = 0;
    chk("cr_we", 32'(we), 32'd0);
    chk("cr_ready", 32'(rx_ready), 32'd1);
    chk_cursor("cr");
    lf();
    chk("lf_we", 32'(we), 32'd0);
    chk_cursor("lf");
    send(8'h08, 8'h00);
    chk("bs0_we", 32'(we), 32'd0);
    chk_cursor("bs0");

    // Line wrap from (79,2)
    do_reset();
    lf();
    lf();
    for (int i = 0; i < 79; i++) print(8'h61 + 8'(i % 26), 8'h07);
    chk_cursor("at792");
    expect_write(239, 16'h075A);
    send(8'h5A, 8'h07);
    tick();
    ex = 0;
    ey = 3;
    chk_cursor("wrap");

    // Scroll by LF on the last row
    do_preload();
    do_reset();
    for (int i = 0; i < 24; i++) lf();
    chk_cursor("at024");
    expect_scroll();
    send(8'h0A, 8'h00);
    count_busy(nbusy);
    chk("scroll_busy", 32'(nbusy), 32'd3920);
    chk_cursor("scroll");
    for (int i = 0; i < 2000; i++)
      chk("scroll_ram", 32'(ram[i]), (i < 1920) ? 32'(i + 80) : 32'h0720);

    // Scroll by printable wrap at (79,24)
    for (int i = 0; i < 79; i++) print(8'h41 + 8'(i % 26), 8'h1F);
    expect_write(1999, 16'h2E7E);
    expect_scroll();
    send(8'h7E, 8'h2E);
    count_busy(nbusy);
    chk("wrapscroll_busy", 32'(nbusy), 32'd3921);
    ex = 0;
    chk_cursor("wrapscroll");
    chk("wrapscroll_row23_end", 32'(ram[1919]), 32'h2E7E);
    chk("wrapscroll_row23_start", 32'(ram[1840]), 32'h1F41);
    chk("wrapscroll_fill", 32'(ram[1999]), 32'h0720);

    // Clear wins over a simultaneous byte
    rx_data  = 8'h42;
    rx_attr  = 8'h07;
    rx_valid = 1'b1;
    clear    = 1'b1;
    #1;
    chk("clear_ready", 32'(rx_ready), 32'd0);
    for (int i = 0; i < 2000; i++) expect_write(i, 16'h0720);
    tick();
    rx_valid = 1'b0;
    clear    = 1'b0;
    count_busy(nbusy);
    chk("clear_busy", 32'(nbusy), 32'd2000);
    ex = 0;
    ey = 0;
    chk_cursor("clear");
    chk("clear_ram0", 32'(ram[0]), 32'h0720);

    // Reset 100 cycles into a scroll
    do_preload();
    for (int i = 0; i < 24; i++) lf();
    expect_scroll();
    send(8'h0A, 8'h00);
    repeat (99) tick();
    reset_n = 1'b0;
    tick();
    chk("abort_we", 32'(we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    ex = 0;
    ey = 0;
    chk_cursor("abort");
    sb.delete();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 2000; i++)
      chk("abort_ram", 32'(ram[i]), (i < 50) ? 32'(i + 80) : 32'(i));

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
